regfile_wb_arbiter: RTL and testbench

Write-back arbiter sharing the register file's single write port (RW/BusW/RegWr) between two producers: port 0 (ALU result) and port 1 (load/memory result). Each port has a one-entry holding slot with a valid/ready handshake. Grants are round-robin or fixed-priority, and same-destination write order is preserved. The block drives registered RW/BusW/RegWr into the 32×64 register file, which commits on the negative edge. It also flags read-after-write hazards on the read addresses RA/RB for the stall logic.

---
 rtl/regfile_wb_arbiter.sv | 171 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// port 0 (ALU result) and port 1 (load result). Each port owns a one-entry
// holding slot; the winner of each cycle is registered onto RegWr/RW/BusW.
// Writes to the same destination leave in acceptance order. RA/RB hazard
// flags cover both pending slots and the registered write not yet committed.
// Optional feature macro: WB_ARB_ROUND_ROBIN_EN (round-robin between
// different-destination contenders; when undefined port 1 always wins).
module regfile_wb_arbiter #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Req0,
  input  logic [AW-1:0] Rd0,
  input  logic [DW-1:0] Data0,
  input  logic          Req1,
  input  logic [AW-1:0] Rd1,
  input  logic [DW-1:0] Data1,
  output logic          Ready0,
  output logic          Ready1,
  input  logic [AW-1:0] RA,
  input  logic [AW-1:0] RB,
  output logic          HazA,
  output logic          HazB,
  output logic          RegWr,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] BusW
);

  localparam logic [AW-1:0] ZeroReg = {AW{1'b1}};

  logic          full0_r, full1_r;
  logic [AW-1:0] slotRd0_r, slotRd1_r;
  logic [DW-1:0] slotData0_r, slotData1_r;
  logic          olderOne_r;      // 1: slot 1 holds the older entry
  logic          grant0_s, grant1_s;
  logic          accept0_s, accept1_s;
  logic          load0_s, load1_s;
`ifdef WB_ARB_ROUND_ROBIN_EN
  logic          rrFavour1_r;     // 1: port 1 wins the next different-Rd contention
  logic          contend_s;
`endif

  // Pending-write match for one read address; the zero register never hazards.
  function automatic logic hazardMatch(
    input logic [AW-1:0] addr,
    input logic          f0,
    input logic [AW-1:0] r0,
    input logic          f1,
    input logic [AW-1:0] r1,
    input logic          wr,
    input logic [AW-1:0] rw
  );
    return (addr != ZeroReg) &&
           ((f0 && (r0 == addr)) || (f1 && (r1 == addr)) || (wr && (rw == addr)));
  endfunction

  // Arbitration over the full slots: same-Rd goes to the older entry, different-Rd by policy.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
    contend_s = 1'b0;
`endif
    if (full0_r && full1_r) begin
      if (slotRd0_r == slotRd1_r) begin
        grant0_s = !olderOne_r;
        grant1_s = olderOne_r;
      end else begin
`ifdef WB_ARB_ROUND_ROBIN_EN
        contend_s = 1'b1;
        grant0_s  = !rrFavour1_r;
        grant1_s  = rrFavour1_r;
`else
        grant1_s  = 1'b1;
`endif
      end
    end else if (full0_r) begin
      grant0_s = 1'b1;
    end else if (full1_r) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // A slot can take a new entry when empty or when it drains this cycle.
  assign Ready0    = !Reset && (!full0_r || grant0_s);
  assign Ready1    = !Reset && (!full1_r || grant1_s);
  assign accept0_s = Req0 && Ready0;
  assign accept1_s = Req1 && Ready1;
  assign load0_s   = accept0_s && (Rd0 != ZeroReg);
  assign load1_s   = accept1_s && (Rd1 != ZeroReg);

  assign HazA = !Reset && hazardMatch(RA, full0_r, slotRd0_r, full1_r, slotRd1_r, RegWr, RW);
  assign HazB = !Reset && hazardMatch(RB, full0_r, slotRd0_r, full1_r, slotRd1_r, RegWr, RW);

  // Slot 0: load on accepted non-zero write, otherwise empty after accept-drop or grant.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      full0_r     <= 1'b0;
      slotRd0_r   <= {AW{1'b0}};
      slotData0_r <= {DW{1'b0}};
    end else if (load0_s) begin
      full0_r     <= 1'b1;
      slotRd0_r   <= Rd0;
      slotData0_r <= Data0;
    end else if (accept0_s || grant0_s) begin
      full0_r     <= 1'b0;
    end
  end

  // Slot 1: same behaviour as slot 0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      full1_r     <= 1'b0;
      slotRd1_r   <= {AW{1'b0}};
      slotData1_r <= {DW{1'b0}};
    end else if (load1_s) begin
      full1_r     <= 1'b1;
      slotRd1_r   <= Rd1;
      slotData1_r <= Data1;
    end else if (accept1_s || grant1_s) begin
      full1_r     <= 1'b0;
    end
  end

  // Age bit: a lone new entry is younger than the other slot; a same-cycle pair counts slot 0 as older.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      olderOne_r <= 1'b0;
    end else if (load0_s && !load1_s) begin
      olderOne_r <= 1'b1;
    end else if (load1_s) begin
      olderOne_r <= 1'b0;
    end
  end

`ifdef WB_ARB_ROUND_ROBIN_EN
  // Round-robin pointer: after a contended grant, favour the port that lost.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rrFavour1_r <= 1'b0;
    end else if (contend_s) begin
      rrFavour1_r <= grant0_s;
    end
  end
`endif

  // Register-file write port: winner's entry is registered; address/data hold when idle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWr <= 1'b0;
      RW    <= {AW{1'b0}};
      BusW  <= {DW{1'b0}};
    end else if (grant0_s) begin
      RegWr <= 1'b1;
      RW    <= slotRd0_r;
      BusW  <= slotData0_r;
    end else if (grant1_s) begin
      RegWr <= 1'b1;
      RW    <= slotRd1_r;
      BusW  <= slotData1_r;
    end else begin
      RegWr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed steps followed by a random phase,
// every cycle compared against a queue-based reference model that orders
// pending writes by a global acceptance sequence number.
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req0, Req1;
  logic [4:0]  Rd0, Rd1;
  logic [63:0] Data0, Data1;
  logic        Ready0, Ready1;
  logic [4:0]  RA, RB;
  logic        HazA, HazB;
  logic        RegWr;
  logic [4:0]  RW;
  logic [63:0] BusW;

  regfile_wb_arbiter #(.DW(64), .AW(5)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Rd0(Rd0), .Data0(Data0),
    .Req1(Req1), .Rd1(Rd1), .Data1(Data1),
    .Ready0(Ready0), .Ready1(Ready1),
    .RA(RA), .RB(RB), .HazA(HazA), .HazB(HazB),
    .RegWr(RegWr), .RW(RW), .BusW(BusW)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    int unsigned seq;
  } entry_t;

  entry_t      pend0[$];
  entry_t      pend1[$];
  logic        mRegWr;
  logic [4:0]  mRW;
  logic [63:0] mBusW;
  bit          favour1;
  int unsigned seqCnt;
  int          checkCnt = 0;
  int          passCnt  = 0;
  int          failCnt  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    pend0.delete();
    pend1.delete();
    mRegWr  = 1'b0;
    mRW     = 5'd0;
    mBusW   = 64'd0;
    favour1 = 1'b0;
    seqCnt  = 0;
  endfunction

  // Which port writes this cycle: -1 none, else 0/1.
  function automatic int pickWinner(output bit contended);
    contended = 1'b0;
    if (pend0.size() != 0 && pend1.size() != 0) begin
      if (pend0[0].rd == pend1[0].rd)
        return (pend0[0].seq < pend1[0].seq) ? 0 : 1;
      contended = 1'b1;
`ifdef WB_ARB_ROUND_ROBIN_EN
      return favour1 ? 1 : 0;
`else
      return 1;
`endif
    end
    if (pend0.size() != 0) return 0;
    if (pend1.size() != 0) return 1;
    return -1;
  endfunction

  function automatic logic mHaz(input logic [4:0] a);
    logic h;
    h = 1'b0;
    if (a == 5'd31) return 1'b0;
    foreach (pend0[i]) if (pend0[i].rd == a) h = 1'b1;
    foreach (pend1[i]) if (pend1[i].rd == a) h = 1'b1;
    if (mRegWr && mRW == a) h = 1'b1;
    return h;
  endfunction

  // One clock: check combinational outputs, advance the model across the
  // posedge, check the registered outputs, return at the next negedge.
  task automatic tick();
    int      win;
    bit      contended, r0, r1, q0, q1;
    entry_t  e;
    logic [4:0]  d0, d1;
    logic [63:0] x0, x1;
    #1;
    win = pickWinner(contended);
    r0  = (pend0.size() == 0) || (win == 0);
    r1  = (pend1.size() == 0) || (win == 1);
    check("Ready0", Ready0, r0);
    check("Ready1", Ready1, r1);
    check("HazA", HazA, mHaz(RA));
    check("HazB", HazB, mHaz(RB));
    q0 = Req0; q1 = Req1; d0 = Rd0; d1 = Rd1; x0 = Data0; x1 = Data1;
    @(posedge Clk);
    if (win == 0) begin
      e = pend0.pop_front();
      mRegWr = 1'b1; mRW = e.rd; mBusW = e.data;
    end else if (win == 1) begin
      e = pend1.pop_front();
      mRegWr = 1'b1; mRW = e.rd; mBusW = e.data;
    end else begin
      mRegWr = 1'b0;
    end
    if (contended) favour1 = (win == 0);
    if (q0 && r0 && d0 != 5'd31) begin
      e.rd = d0; e.data = x0; e.seq = seqCnt; seqCnt++;
      pend0.push_back(e);
    end
    if (q1 && r1 && d1 != 5'd31) begin
      e.rd = d1; e.data = x1; e.seq = seqCnt; seqCnt++;
      pend1.push_back(e);
    end
    #1;
    check("RegWr", RegWr, mRegWr);
    check("RW", RW, mRW);
    check("BusW", BusW, mBusW);
    @(negedge Clk);
  endtask

  initial begin
    // Reset with a request pending: nothing accepted, outputs cleared.
    Reset = 1'b1; Req0 = 1'b1; Rd0 = 5'd5; Data0 = 64'hA5;
    Req1 = 1'b0; Rd1 = 5'd0; Data1 = 64'd0; RA = 5'd0; RB = 5'd0;
    modelReset();
    #2;
    check("rst_Ready0", Ready0, 1'b0);
    check("rst_RegWr", RegWr, 1'b0);
    check("rst_RW", RW, 5'd0);
    check("rst_BusW", BusW, 64'd0);
    check("rst_HazA", HazA, 1'b0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    // First write: accepted, then visible one cycle later.
    tick();
    Req0 = 1'b0;
    tick();
    check("first_RegWr", RegWr, 1'b1);
    check("first_RW", RW, 5'd5);
    check("first_BusW", BusW, 64'hA5);

    // Zero-register drop.
    Req0 = 1'b1; Rd0 = 5'd31; Data0 = 64'hFF; RA = 5'd31;
    tick();
    Req0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("zero_RegWr", RegWr, 1'b0);
      check("zero_HazA", HazA, 1'b0);
    end

    // Same destination, same cycle: port 0 first, port 1 last.
    Req0 = 1'b1; Rd0 = 5'd7; Data0 = 64'd1;
    Req1 = 1'b1; Rd1 = 5'd7; Data1 = 64'd2;
    tick();
    Req0 = 1'b0; Req1 = 1'b0;
    tick();
    check("same_rd_first_RW", RW, 5'd7);
    check("same_rd_first_BusW", BusW, 64'd1);
    tick();
    check("same_rd_second_RW", RW, 5'd7);
    check("same_rd_second_BusW", BusW, 64'd2);
    tick();

    // Continuous contention on different destinations, then port 1 idles.
    Req0 = 1'b1; Rd0 = 5'd3; Req1 = 1'b1; Rd1 = 5'd4;
    for (int i = 0; i < 8; i++) begin
      Data0 = {32'd0, $urandom}; Data1 = {32'd1, $urandom};
      tick();
    end
    Req1 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    Req0 = 1'b0;
    tick();
    tick();

    // Back-to-back stream on port 0.
    for (int i = 1; i <= 8; i++) begin
      Req0 = 1'b1; Rd0 = 5'(i); Data0 = 64'(i) * 64'h111;
      tick();
      check("stream_Ready0", Ready0, 1'b1);
    end
    Req0 = 1'b0;
    tick();
    check("stream_last_RW", RW, 5'd8);
    tick();

    // Hazard on a pending write to register 9.
    RA = 5'd9; RB = 5'd9; Req0 = 1'b1; Rd0 = 5'd9; Data0 = 64'h99;
    tick();
    Req0 = 1'b0;
    #1;
    check("haz_slot_HazA", HazA, 1'b1);
    tick();
    check("haz_wr_RW", RW, 5'd9);
    check("haz_wr_HazA", HazA, 1'b1);
    tick();
    check("haz_done_HazB", HazB, 1'b0);

    // Random traffic with small address range to force collisions.
    for (int i = 0; i < 400; i++) begin
      Req0  = 1'($urandom_range(0, 1));
      Req1  = 1'($urandom_range(0, 1));
      Rd0   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      Rd1   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 5));
      Data0 = {$urandom, $urandom};
      Data1 = {$urandom, $urandom};
      RA    = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
      RB    = 5'($urandom_range(0, 6));
      tick();
    end

    // Reset mid-stream: write enable drops without a clock edge, slots emptied.
    Req0 = 1'b1; Rd0 = 5'd12; Data0 = 64'hC; Req1 = 1'b1; Rd1 = 5'd13; Data1 = 64'hD;
    RA = 5'd12; RB = 5'd13;
    tick();
    tick();
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_RegWr", RegWr, 1'b0);
    check("midrst_Ready0", Ready0, 1'b0);
    check("midrst_Ready1", Ready1, 1'b0);
    check("midrst_HazA", HazA, 1'b0);
    modelReset();
    @(negedge Clk);
    Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    tick();
    check("postrst_RegWr", RegWr, 1'b0);
    tick();
    check("postrst_HazB", HazB, 1'b0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
